// File: rtl/cpu_pkg.sv
// Shared types and default constants for the CPU clock controller.
package cpu_pkg;

    typedef enum logic [1:0] {
        STEP_WAIT = 2'd0,
        STEP_HI   = 2'd1,
        RUN       = 2'd2,
        HALTED    = 2'd3
    } cpu_state_t;

    localparam int DEF_CLOCK    = 10_000_000;
    localparam int DEF_DEBOUNCE = 1_000_000;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button -> 2-FF synchronizer -> stability filter -> one-cycle press pulse.
module button_debounce
    import cpu_pkg::*;
#(
    parameter int PAR_DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic press
);

    localparam int CW = cnt_width(PAR_DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PAR_DEBOUNCE - 1);

    logic [1:0]    sync_reg;
    logic          level_reg, level_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          press_reg, press_next;

    // The level flips only after PAR_DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        level_next = level_reg;
        cnt_next   = '0;
        press_next = 1'b0;
        if (sync_reg[1] != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = sync_reg[1];
                press_next = sync_reg[1];
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_reg  <= 2'b00;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], raw};
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
            press_reg <= press_next;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock generator: free-run divider, debounced single-step and halt handling.
module cpu_clock_ctrl
    import cpu_pkg::*;
#(
    parameter int PAR_CLOCK    = DEF_CLOCK,
    parameter int PAR_DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUTTON,
    input  logic        MODE_RUN,
    input  logic        HALT,
    output logic        CPU_CLOCK,
    output logic        TICK,
    output logic [1:0]  STATE,
    output logic [15:0] CYCLES
);

    localparam int DW = cnt_width(PAR_CLOCK);
    localparam logic [DW-1:0] DIV_LAST  = DW'(PAR_CLOCK - 1);
    localparam logic [DW-1:0] HALF      = DW'(PAR_CLOCK / 2);
    localparam logic [DW-1:0] HALF_LAST = DW'(PAR_CLOCK / 2 - 1);

    cpu_state_t    state_reg, state_next;
    logic [DW-1:0] div_reg, div_next;
    logic          clk_reg, clk_next;
    logic          tick_reg, tick_next;
    logic          halt_pend_reg, halt_pend_next;
    logic [15:0]   cycles_reg, cycles_next;
    logic          press;

    button_debounce #(
        .PAR_DEBOUNCE(PAR_DEBOUNCE)
    ) u_debounce (
        .CLK  (CLK),
        .RESET(RESET),
        .raw  (BUTTON),
        .press(press)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= STEP_WAIT;
            div_reg       <= '0;
            clk_reg       <= 1'b0;
            tick_reg      <= 1'b0;
            halt_pend_reg <= 1'b0;
            cycles_reg    <= 16'd0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            clk_reg       <= clk_next;
            tick_reg      <= tick_next;
            halt_pend_reg <= halt_pend_next;
            cycles_reg    <= cycles_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        halt_pend_next = halt_pend_reg;

        case (state_reg)
            STEP_WAIT: begin
                div_next = '0;
                if (HALT) begin
                    state_next = HALTED;
                end else if (MODE_RUN) begin
                    state_next = RUN;
                end else if (press) begin
                    state_next = STEP_HI;
                end
            end
            STEP_HI: begin
                // A halt seen anywhere in the pulse is deferred to its end.
                halt_pend_next = halt_pend_reg | HALT;
                if (div_reg == HALF_LAST) begin
                    div_next   = '0;
                    state_next = (halt_pend_reg || HALT) ? HALTED : STEP_WAIT;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            RUN: begin
                if (HALT && !clk_reg) begin
                    state_next = HALTED;
                    div_next   = '0;
                end else if (div_reg == DIV_LAST) begin
                    // Leaving RUN only at the period boundary avoids runt pulses.
                    div_next = '0;
                    if (halt_pend_reg || HALT) begin
                        state_next = HALTED;
                    end else if (!MODE_RUN) begin
                        state_next = STEP_WAIT;
                    end
                end else begin
                    div_next       = div_reg + 1'b1;
                    halt_pend_next = halt_pend_reg | HALT;
                end
            end
            HALTED: begin
                div_next = '0;
            end
            default: begin
                state_next = STEP_WAIT;
                div_next   = '0;
            end
        endcase

        if (state_next == STEP_WAIT || state_next == HALTED) begin
            halt_pend_next = 1'b0;
        end

        clk_next    = (state_next == STEP_HI) || ((state_next == RUN) && (div_next >= HALF));
        tick_next   = clk_next & ~clk_reg;
        cycles_next = cycles_reg + {15'd0, tick_next};
    end

    assign CPU_CLOCK = clk_reg;
    assign TICK      = tick_reg;
    assign STATE     = state_reg;
    assign CYCLES    = cycles_reg;

endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 Parameter PAR_CLOCK, default 10_000_000, meaning: CPU clock period in CLK cycles (even, >=4).
REQ-002 Parameter PAR_DEBOUNCE, default 1_000_000, meaning: CLK cycles a raw button level must hold to count as stable (>=2).
REQ-003 Port CLK  input  1  system clock; the single clock; all state updates on its rising edge.
REQ-004 Port RESET  input  1  reset, asynchronous, active-high.
REQ-005 Port BUTTON  input  1  raw, asynchronous single-step button, high = pressed.
REQ-006 Port MODE_RUN  input  1  1 = free-run, 0 = single-step.
REQ-007 Port HALT  input  1  CPU halt request, synchronous to CLK.
REQ-008 Port CPU_CLOCK  output  1  registered CPU clock level (also drives the LED).
REQ-009 Port TICK  output  1  one-CLK pulse in the cycle CPU_CLOCK goes 0->1.
REQ-010 Port STATE  output  2  current FSM state encoding.
REQ-011 Port CYCLES  output  16  count of CPU clock rising edges since reset.

Function
REQ-012 FSM states: STEP_WAIT=0, STEP_HI=1, RUN=2, HALTED=3.
REQ-013 Divider counter runs 0..PAR_CLOCK-1 and wraps to 0; in RUN, CPU_CLOCK = (counter >= PAR_CLOCK/2).
REQ-014 In STEP_WAIT and HALTED, CPU_CLOCK = 0 and the divider is held at 0.
REQ-015 STEP_WAIT -> RUN when MODE_RUN=1; the divider starts at 0, so the first high phase begins PAR_CLOCK/2 cycles later.
REQ-016 STEP_WAIT -> STEP_HI on a debounced press event; CPU_CLOCK is 1 for exactly PAR_CLOCK/2 cycles, then the FSM returns to STEP_WAIT.
REQ-017 RUN -> STEP_WAIT only at divider wrap (end of a full period) with MODE_RUN=0; no runt pulses.
REQ-018 Press events in RUN, STEP_HI or HALTED are discarded, not queued.
REQ-019 MODE_RUN changes during STEP_HI take effect only after STEP_HI completes.
REQ-020 HALT=1 while CPU_CLOCK=1 (RUN or STEP_HI): finish the current high phase, then enter HALTED with CPU_CLOCK=0.
REQ-021 HALT=1 while CPU_CLOCK=0 in RUN or STEP_WAIT: enter HALTED next cycle.
REQ-022 HALTED is left only by RESET.
REQ-023 Debounce: 2-FF synchronizer, then a stability counter; the debounced level changes after PAR_DEBOUNCE consecutive cycles of the synchronized level differing from it.
REQ-024 Press event = one-cycle pulse on a debounced 0->1 transition.
REQ-025 TICK is asserted for exactly one CLK per CPU_CLOCK rising edge, in the same cycle CPU_CLOCK becomes 1.
REQ-026 CYCLES increments on every TICK and wraps 0xFFFF -> 0x0000.
REQ-027 HALT and a press event in the same cycle in STEP_WAIT: HALT wins and no step occurs.

Reset
REQ-028 Reset state: STEP_WAIT, CPU_CLOCK=0, TICK=0, CYCLES=0, divider=0, debounced level=0, synchronizer and stability counter cleared.
REQ-029 Reset mid-pulse drops CPU_CLOCK to 0 immediately (asynchronously) and emits no TICK.
REQ-030 After reset release, STEP_WAIT -> RUN occurs in the first cycle if MODE_RUN=1.

Structure
REQ-031 The state enum and default parameter constants live in shared package cpu_pkg.
REQ-032 Debounce and edge detection form sub-module button_debounce (CLK, RESET, raw in, press pulse out, parameter PAR_DEBOUNCE).

Verification
REQ-033 All scenarios use PAR_CLOCK=8 and PAR_DEBOUNCE=4.
REQ-034 RUN: MODE_RUN=1 for 40 cycles -> CPU_CLOCK 4 low/4 high, 5 TICKs, CYCLES=5.
REQ-035 STEP: BUTTON bounces 1,0,1, then holds 1 for 10 cycles -> exactly one 4-cycle high pulse and CYCLES=1; a second press during STEP_HI is ignored.
REQ-036 Mode switch: MODE_RUN 1->0 at divider=5 -> current period completes, then STATE=0 with no runt pulse.
REQ-037 HALT in high phase at divider=5 -> CPU_CLOCK falls at divider wrap, STATE=3, and stays there despite button presses and MODE_RUN toggles.
REQ-038 Async RESET asserted mid-STEP_HI -> CPU_CLOCK=0 without waiting for a CLK edge, CYCLES=0, STATE=0.
REQ-039 CYCLES preset near wrap via 65536 RUN periods -> reads 0x0000 after the 65536th TICK.
